// File: rtl/cmip_pkg.sv
// ---------------------------------------------------------------------------
// cmip_pkg
// Shared definitions for the easy packet checker:
//   - checker state encoding (DIS / HUNT / RUN)
//   - tready backpressure pattern codes
//   - default packet length used when cfg_len is 0
//   - cfg_mode bit positions
//   - LFSR step function for the backpressure generator
// ---------------------------------------------------------------------------
package cmip_pkg;

   typedef enum logic [1:0] {
      ST_DIS  = 2'd0,
      ST_HUNT = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      BP_ON   = 2'd0,   // tready always 1
      BP_ALT  = 2'd1,   // alternate 1/0, starting at 1
      BP_LFSR = 2'd2,   // pseudo-random from LFSR bit 0
      BP_OFF  = 2'd3    // tready always 0
   } bp_e;

   localparam int          DEF_LEN     = 8;
   localparam int          PATTERN_BIT = 1;
   localparam int          LANE_WD     = 32;
   localparam logic [15:0] LFSR_SEED   = 16'h0001;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11; new bit enters at bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

endpackage

// File: rtl/cmip_bp_gen.sv
// ---------------------------------------------------------------------------
// cmip_bp_gen
// Produces the raw tready pattern bit for the checker. The caller registers
// it, so the pattern reaches s_axis_tready one cycle after cfg_bp changes.
//   clk, rst : clock, synchronous active-high clear (rst or cfg_rst)
//   en       : checker enable; LFSR and toggle only advance while set
//   bp       : pattern select (see bp_e)
//   bp_bit   : pattern bit for the next cycle
// ---------------------------------------------------------------------------
module cmip_bp_gen
   import cmip_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] bp,
   output logic       bp_bit
);

   logic [15:0] lfsr_q, lfsr_d;
   logic        alt_q,  alt_d;

   always_comb begin
      lfsr_d = en ? lfsr_next(lfsr_q) : lfsr_q;
      // Toggle phase is re-armed while disabled so the alternating pattern
      // always opens with a 1 after enable.
      alt_d  = en ? ~alt_q : 1'b1;
      unique case (bp_e'(bp))
         BP_ON:   bp_bit = 1'b1;
         BP_ALT:  bp_bit = alt_q;
         BP_LFSR: bp_bit = lfsr_q[0];
         default: bp_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
         alt_q  <= 1'b1;
      end else begin
         lfsr_q <= lfsr_d;
         alt_q  <= alt_d;
      end
   end

endmodule

// File: rtl/cmip_pkt_chk_easy.sv
// ---------------------------------------------------------------------------
// cmip_pkt_chk_easy
// AXI-Stream checker for the easy packet generator traffic. Verifies packet
// length, SOP marking (tuser), tkeep and the lane-replicated counter pattern,
// and keeps saturating status counters.
//   clk, rst           : clock, synchronous active-high reset
//   cfg_rst            : synchronous clear of counters and state
//   cfg_en             : enable; 0 forces DIS and drops any open packet
//   cfg_len            : expected beats per packet (0 means 8)
//   cfg_mode[1]        : 1 = counter pattern, 0 = all-zero data
//   cfg_bp             : tready pattern select
//   sts_*              : status (locked, sticky error, counters)
//   s_axis_*           : AXI-Stream slave; tuser marks start of packet
// ---------------------------------------------------------------------------
module cmip_pkt_chk_easy
   import cmip_pkg::*;
#(
   parameter int DATA_WD = 128,
   parameter int CFG_WD  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_rst,
   input  logic                 cfg_en,
   input  logic [CFG_WD-1:0]    cfg_len,
   input  logic [CFG_WD-1:0]    cfg_mode,
   input  logic [1:0]           cfg_bp,
   output logic                 sts_locked,
   output logic                 sts_err,
   output logic [CFG_WD-1:0]    sts_pkt_cnt,
   output logic [CFG_WD-1:0]    sts_beat_cnt,
   output logic [CFG_WD-1:0]    sts_len_err_cnt,
   output logic [CFG_WD-1:0]    sts_data_err_cnt,
   output logic [CFG_WD-1:0]    sts_sop_err_cnt,
   input  logic [DATA_WD-1:0]   s_axis_tdata,
   input  logic [DATA_WD/8-1:0] s_axis_tkeep,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tuser
);

   localparam int LANES = DATA_WD / LANE_WD;

   function automatic logic [CFG_WD-1:0] sat_inc(input logic [CFG_WD-1:0] v,
                                                 input logic inc);
      return (inc && !(&v)) ? v + CFG_WD'(1) : v;
   endfunction

   logic                clr;
   logic                bp_bit;
   logic                acc;
   logic                keep_ok;
   logic                lane_mis;
   logic [LANE_WD-1:0]  lane0;
   logic [CFG_WD-1:0]   len_imp;

   state_e              state_q,    state_d;
   logic                locked_q,   locked_d;
   logic                tready_q,   tready_d;
   logic                in_pkt_q,   in_pkt_d;
   logic                len_flag_q, len_flag_d;   // len_err already counted for this packet
   logic [CFG_WD-1:0]   beat_idx_q, beat_idx_d;
   logic [LANE_WD-1:0]  exp_q,      exp_d;
   logic                err_q,      err_d;
   logic [CFG_WD-1:0]   pkt_q,  pkt_d;
   logic [CFG_WD-1:0]   beat_q, beat_d;
   logic [CFG_WD-1:0]   lerr_q, lerr_d;
   logic [CFG_WD-1:0]   derr_q, derr_d;
   logic [CFG_WD-1:0]   serr_q, serr_d;

   logic                start_pkt, do_len;
   logic                len_inc, data_inc, sop_inc, pkt_inc;
   logic                cur_flag;
   logic [CFG_WD-1:0]   cur_idx, nxt_idx;

   assign clr     = rst | cfg_rst;
   assign acc     = s_axis_tvalid & tready_q;
   assign keep_ok = &s_axis_tkeep;
   assign lane0   = s_axis_tdata[LANE_WD-1:0];
   assign len_imp = (cfg_len == '0) ? CFG_WD'(DEF_LEN) : cfg_len;

   cmip_bp_gen u_bp (
      .clk    (clk),
      .rst    (clr),
      .en     (cfg_en),
      .bp     (cfg_bp),
      .bp_bit (bp_bit)
   );

   always_comb begin
      lane_mis = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (cfg_mode[PATTERN_BIT]) begin
            if (s_axis_tdata[i*LANE_WD +: LANE_WD] != exp_q) lane_mis = 1'b1;
         end else begin
            if (s_axis_tdata[i*LANE_WD +: LANE_WD] != '0) lane_mis = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      in_pkt_d   = in_pkt_q;
      beat_idx_d = beat_idx_q;
      len_flag_d = len_flag_q;
      exp_d      = exp_q;
      start_pkt  = 1'b0;
      do_len     = 1'b0;
      len_inc    = 1'b0;
      data_inc   = 1'b0;
      sop_inc    = 1'b0;
      pkt_inc    = 1'b0;
      cur_idx    = '0;
      cur_flag   = 1'b0;
      nxt_idx    = '0;

      if (!cfg_en) begin
         state_d    = ST_DIS;
         in_pkt_d   = 1'b0;
         beat_idx_d = '0;
         len_flag_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_DIS: state_d = ST_HUNT;
            ST_HUNT: begin
               // Discard until an SOP; that beat seeds the expected counter.
               if (acc && s_axis_tuser) begin
                  state_d   = ST_RUN;
                  exp_d     = lane0 + LANE_WD'(1);
                  start_pkt = 1'b1;
                  do_len    = 1'b1;
               end
            end
            ST_RUN: begin
               if (acc) begin
                  do_len = 1'b1;
                  if (!in_pkt_q) begin
                     start_pkt = 1'b1;
                     if (!s_axis_tuser) sop_inc = 1'b1;
                  end else if (s_axis_tuser) begin
                     // Early SOP: close the open packet as short, restart here.
                     sop_inc   = 1'b1;
                     start_pkt = 1'b1;
                     if (!len_flag_q) len_inc = 1'b1;
                  end
                  if (!keep_ok)  sop_inc  = 1'b1;
                  if (lane_mis)  data_inc = 1'b1;
                  if (cfg_mode[PATTERN_BIT])
                     exp_d = lane_mis ? lane0 + LANE_WD'(1) : exp_q + LANE_WD'(1);
               end
            end
            default: state_d = ST_DIS;
         endcase

         if (do_len) begin
            cur_idx  = start_pkt ? '0 : beat_idx_q;
            cur_flag = start_pkt ? 1'b0 : len_flag_q;
            nxt_idx  = cur_idx + CFG_WD'(1);
            if (s_axis_tlast) begin
               if (nxt_idx != len_imp && !cur_flag) len_inc = 1'b1;
               pkt_inc    = 1'b1;
               beat_idx_d = '0;
               in_pkt_d   = 1'b0;
               len_flag_d = 1'b0;
            end else begin
               beat_idx_d = nxt_idx;
               in_pkt_d   = 1'b1;
               len_flag_d = cur_flag;
               // Overrun: flag once at the expected length, keep going to tlast.
               if (nxt_idx == len_imp && !cur_flag) begin
                  len_inc    = 1'b1;
                  len_flag_d = 1'b1;
               end
            end
         end
      end

      locked_d = (state_d == ST_RUN);
      tready_d = cfg_en & bp_bit;
      err_d    = err_q | len_inc | data_inc | sop_inc;
      pkt_d    = sat_inc(pkt_q,  pkt_inc);
      beat_d   = sat_inc(beat_q, acc);
      lerr_d   = sat_inc(lerr_q, len_inc);
      derr_d   = sat_inc(derr_q, data_inc);
      serr_d   = sat_inc(serr_q, sop_inc);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= ST_DIS;
         locked_q   <= 1'b0;
         tready_q   <= 1'b0;
         in_pkt_q   <= 1'b0;
         len_flag_q <= 1'b0;
         beat_idx_q <= '0;
         exp_q      <= '0;
         err_q      <= 1'b0;
         pkt_q      <= '0;
         beat_q     <= '0;
         lerr_q     <= '0;
         derr_q     <= '0;
         serr_q     <= '0;
      end else begin
         state_q    <= state_d;
         locked_q   <= locked_d;
         tready_q   <= tready_d;
         in_pkt_q   <= in_pkt_d;
         len_flag_q <= len_flag_d;
         beat_idx_q <= beat_idx_d;
         exp_q      <= exp_d;
         err_q      <= err_d;
         pkt_q      <= pkt_d;
         beat_q     <= beat_d;
         lerr_q     <= lerr_d;
         derr_q     <= derr_d;
         serr_q     <= serr_d;
      end
   end

   assign s_axis_tready    = tready_q;
   assign sts_locked       = locked_q;
   assign sts_err          = err_q;
   assign sts_pkt_cnt      = pkt_q;
   assign sts_beat_cnt     = beat_q;
   assign sts_len_err_cnt  = lerr_q;
   assign sts_data_err_cnt = derr_q;
   assign sts_sop_err_cnt  = serr_q;

endmodule

// File: tb/tb_cmip_pkt_chk_easy.sv
// ---------------------------------------------------------------------------
// tb_cmip_pkt_chk_easy
// Scoreboard bench: each driven beat runs through a packet-level reference
// model and the expected status snapshot is queued; a monitor pops one entry
// per observed handshake and compares the status one cycle later.
// ---------------------------------------------------------------------------
module tb_cmip_pkt_chk_easy;

   localparam int DW    = 128;
   localparam int CW    = 32;
   localparam int LANES = DW / 32;
   localparam int KW    = DW / 8;

   logic          clk = 1'b0;
   logic          rst, cfg_rst, cfg_en;
   logic [CW-1:0] cfg_len, cfg_mode;
   logic [1:0]    cfg_bp;
   logic          sts_locked, sts_err;
   logic [CW-1:0] sts_pkt_cnt, sts_beat_cnt, sts_len_err_cnt;
   logic [CW-1:0] sts_data_err_cnt, sts_sop_err_cnt;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;

   cmip_pkt_chk_easy #(.DATA_WD(DW), .CFG_WD(CW)) dut (
      .clk(clk), .rst(rst), .cfg_rst(cfg_rst), .cfg_en(cfg_en),
      .cfg_len(cfg_len), .cfg_mode(cfg_mode), .cfg_bp(cfg_bp),
      .sts_locked(sts_locked), .sts_err(sts_err),
      .sts_pkt_cnt(sts_pkt_cnt), .sts_beat_cnt(sts_beat_cnt),
      .sts_len_err_cnt(sts_len_err_cnt), .sts_data_err_cnt(sts_data_err_cnt),
      .sts_sop_err_cnt(sts_sop_err_cnt),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned pkt, beat, len, data, sop;
      bit          err, locked;
   } snap_t;

   snap_t sb[$];
   int    errors = 0;
   int    checks = 0;
   int    hs_cnt = 0;

   // reference model state
   bit          m_hunt, m_inpkt, m_flag, m_err;
   int unsigned m_nb;
   logic [31:0] m_exp;
   int unsigned m_pkt, m_beat, m_len, m_data, m_sop;
   int unsigned gen_cnt = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic model_clear();
      m_hunt = 1; m_inpkt = 0; m_flag = 0; m_err = 0; m_nb = 0; m_exp = 0;
      m_pkt = 0; m_beat = 0; m_len = 0; m_data = 0; m_sop = 0;
   endtask

   task automatic model_disable();
      m_hunt = 1; m_inpkt = 0; m_flag = 0; m_nb = 0;
   endtask

   // Packet-level view of the rules: count beats in the open packet, flag a
   // length fault once, compare lanes against the running counter.
   task automatic model_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic u, input logic l);
      int unsigned L;
      bit   start, li, di, si, first, active;
      logic [31:0] l0, lane;
      snap_t s;
      L = (cfg_len == 0) ? 8 : cfg_len;
      start = 0; li = 0; di = 0; si = 0; active = 1;
      l0 = d[31:0];
      m_beat++;
      if (m_hunt) begin
         if (!u) active = 0;
         else begin
            m_hunt = 0;
            m_exp  = l0 + 1;
            start  = 1;
         end
      end else begin
         first = !m_inpkt;
         if ((first && !u) || (!first && u) || (k != {KW{1'b1}})) si = 1;
         if (cfg_mode[1]) begin
            for (int i = 0; i < LANES; i++) begin
               lane = d[i*32 +: 32];
               if (lane != m_exp) di = 1;
            end
            m_exp = di ? l0 + 1 : m_exp + 1;
         end else begin
            for (int i = 0; i < LANES; i++) begin
               lane = d[i*32 +: 32];
               if (lane != 0) di = 1;
            end
         end
         if (!first && u) begin
            if (!m_flag) li = 1;
            start = 1;
         end
         if (first) start = 1;
      end
      if (active) begin
         if (start) begin m_nb = 0; m_flag = 0; end
         if (l) begin
            if ((m_nb + 1 != L) && !m_flag) li = 1;
            m_pkt++; m_nb = 0; m_inpkt = 0; m_flag = 0;
         end else begin
            m_nb++; m_inpkt = 1;
            if (m_nb == L && !m_flag) begin li = 1; m_flag = 1; end
         end
      end
      m_len  += li; m_data += di; m_sop += si;
      m_err  = m_err | li | di | si;
      s.pkt = m_pkt; s.beat = m_beat; s.len = m_len; s.data = m_data; s.sop = m_sop;
      s.err = m_err; s.locked = !m_hunt;
      sb.push_back(s);
   endtask

   function automatic logic [DW-1:0] rep(input logic [31:0] v);
      logic [DW-1:0] d;
      for (int i = 0; i < LANES; i++) d[i*32 +: 32] = v;
      return d;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic u, input logic l);
      int n;
      bit took;
      s_axis_tdata = d; s_axis_tkeep = k; s_axis_tuser = u; s_axis_tlast = l;
      s_axis_tvalid = 1'b1;
      model_beat(d, k, u, l);
      n = 0; took = 0;
      while (!took && n < 200) begin
         took = s_axis_tready;
         @(posedge clk); #1;
         n++;
      end
      if (!took) fail_now("accept_timeout");
   endtask

   task automatic drain();
      int n;
      s_axis_tvalid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 500) begin tick(1); n++; end
      if (sb.size() != 0) fail_now("scoreboard_not_drained");
      tick(2);
   endtask

   // Generator-correct packet; optional corruption of lane 2 at counter value bad_at.
   task automatic clean_pkt(input int n, input longint bad_at);
      logic [DW-1:0] d;
      for (int b = 0; b < n; b++) begin
         d = rep(gen_cnt);
         if (longint'(gen_cnt) == bad_at) d[2*32 +: 32] = 32'hDEAD;
         send(d, {KW{1'b1}}, b == 0, b == n - 1);
         gen_cnt++;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pkt"},    sts_pkt_cnt, 0);
      chk({tag, "_beat"},   sts_beat_cnt, 0);
      chk({tag, "_len"},    sts_len_err_cnt, 0);
      chk({tag, "_data"},   sts_data_err_cnt, 0);
      chk({tag, "_sop"},    sts_sop_err_cnt, 0);
      chk({tag, "_err"},    sts_err, 0);
      chk({tag, "_locked"}, sts_locked, 0);
      chk({tag, "_tready"}, s_axis_tready, 0);
   endtask

   // monitor: one scoreboard entry per handshake, compared after the update edge
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         if (s_axis_tvalid && s_axis_tready && !rst && !cfg_rst) begin
            hs_cnt++;
            @(negedge clk);
            if (sb.size() == 0) fail_now("unexpected_handshake");
            else begin
               e = sb.pop_front();
               chk("mon_pkt",    sts_pkt_cnt,      e.pkt);
               chk("mon_beat",   sts_beat_cnt,     e.beat);
               chk("mon_len",    sts_len_err_cnt,  e.len);
               chk("mon_data",   sts_data_err_cnt, e.data);
               chk("mon_sop",    sts_sop_err_cnt,  e.sop);
               chk("mon_err",    sts_err,          e.err);
               chk("mon_locked", sts_locked,       e.locked);
            end
         end
      end
   end

   initial begin
      int unsigned b0, l0, d0, s0, p0, h0, ones, pos, plen;
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic u;
      rst = 1; cfg_rst = 0; cfg_en = 0; cfg_len = 4; cfg_mode = 32'd2; cfg_bp = 0;
      s_axis_tdata = '0; s_axis_tkeep = '1; s_axis_tvalid = 0;
      s_axis_tlast = 0; s_axis_tuser = 0;
      model_clear();
      tick(3);
      rst = 0;
      tick(1);
      check_zero("reset");

      // ten clean packets of 4 beats, counter 0..39
      cfg_en = 1;
      tick(2);
      for (int p = 0; p < 10; p++) clean_pkt(4, -1);
      drain();
      chk("tp1_pkt", sts_pkt_cnt, 10);
      chk("tp1_beat", sts_beat_cnt, 40);
      chk("tp1_err", sts_err, 0);
      chk("tp1_locked", sts_locked, 1);

      // corrupted lane mid-stream; resync afterwards
      for (int p = 0; p < 5; p++) clean_pkt(4, 57);
      drain();
      chk("tp2_data", sts_data_err_cnt, 1);
      chk("tp2_err", sts_err, 1);

      // 5-beat then 3-beat packet against cfg_len=4
      l0 = sts_len_err_cnt; p0 = sts_pkt_cnt;
      clean_pkt(5, -1);
      clean_pkt(3, -1);
      drain();
      chk("tp3_len", sts_len_err_cnt - l0, 2);
      chk("tp3_pkt", sts_pkt_cnt - p0, 2);

      // missing SOP on first beat, then early SOP on beat 2
      s0 = sts_sop_err_cnt; l0 = sts_len_err_cnt;
      for (int b = 0; b < 4; b++) begin
         send(rep(gen_cnt), '1, 1'b0, b == 3); gen_cnt++;
      end
      drain();
      chk("tp4_sop1", sts_sop_err_cnt - s0, 1);
      for (int b = 0; b < 5; b++) begin
         send(rep(gen_cnt), '1, b < 2, b == 4); gen_cnt++;
      end
      drain();
      chk("tp4_sop2", sts_sop_err_cnt - s0, 2);
      chk("tp4_len", sts_len_err_cnt - l0, 1);

      // bad tkeep and all-zero mode
      send(rep(gen_cnt), 16'h7FFF, 1'b1, 1'b0); gen_cnt++;
      send(rep(gen_cnt), '1, 1'b0, 1'b0); gen_cnt++;
      send(rep(gen_cnt), '1, 1'b0, 1'b0); gen_cnt++;
      send(rep(gen_cnt), '1, 1'b0, 1'b1); gen_cnt++;
      drain();
      cfg_mode = 32'd0;
      send(rep(0), '1, 1'b1, 1'b0);
      send(rep(0), '1, 1'b0, 1'b0);
      send(rep(32'h10), '1, 1'b0, 1'b0);
      send(rep(0), '1, 1'b0, 1'b1);
      drain();
      cfg_mode = 32'd2;
      send(rep(100), '1, 1'b1, 1'b0);   // first beat after mode switch resyncs
      send(rep(101), '1, 1'b0, 1'b0);
      send(rep(102), '1, 1'b0, 1'b0);
      send(rep(103), '1, 1'b0, 1'b1);
      drain();
      gen_cnt = 104;

      // alternating tready pattern
      cfg_bp = 2'd1;
      tick(3);
      ones = 0;
      for (int i = 0; i < 10; i++) begin ones += s_axis_tready; tick(1); end
      chk("bp_alt_ones", ones, 5);

      // continuous valid under bp=1 and bp=2, 500 beats each
      for (int m = 1; m <= 2; m++) begin
         cfg_bp = 2'(m);
         tick(2);
         b0 = sts_beat_cnt; h0 = hs_cnt;
         l0 = sts_len_err_cnt; d0 = sts_data_err_cnt; s0 = sts_sop_err_cnt;
         for (int p = 0; p < 125; p++) clean_pkt(4, -1);
         drain();
         chk("bp_beats", sts_beat_cnt - b0, 500);
         chk("bp_hs", hs_cnt - h0, 500);
         chk("bp_len", sts_len_err_cnt - l0, 0);
         chk("bp_data", sts_data_err_cnt - d0, 0);
         chk("bp_sop", sts_sop_err_cnt - s0, 0);
      end

      // bp=3 holds tready low even with valid asserted
      cfg_bp = 2'd3;
      tick(2);
      s_axis_tvalid = 1'b1; s_axis_tdata = rep(gen_cnt); s_axis_tuser = 1;
      ones = 0;
      for (int i = 0; i < 10; i++) begin ones += s_axis_tready; tick(1); end
      chk("bp_off_ones", ones, 0);
      s_axis_tvalid = 1'b0;
      cfg_bp = 2'd0;
      tick(2);

      // cfg_len = 0 behaves as 8
      cfg_len = 0;
      l0 = sts_len_err_cnt;
      for (int p = 0; p < 3; p++) clean_pkt(8, -1);
      drain();
      chk("len0_len", sts_len_err_cnt - l0, 0);
      cfg_len = 4;

      // randomized stream with occasional faults
      pos = 0; plen = 4;
      for (int i = 0; i < 400; i++) begin
         if (pos == 0) plen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 4;
         d = rep(gen_cnt);
         if ($urandom_range(0, 19) == 0) d[$urandom_range(0, LANES-1)*32 +: 32] = $urandom;
         k = ($urandom_range(0, 24) == 0) ? KW'($urandom) : '1;
         u = (pos == 0);
         if ($urandom_range(0, 29) == 0) u = ~u;
         send(d, k, u, pos == plen - 1);
         gen_cnt++;
         pos = (pos == plen - 1) ? 0 : pos + 1;
         if ($urandom_range(0, 7) == 0) begin s_axis_tvalid = 0; tick($urandom_range(1, 3)); end
      end
      drain();

      // enable drop mid-packet, then hunt for the next SOP
      send(rep(gen_cnt), '1, 1'b1, 1'b0); gen_cnt++;
      send(rep(gen_cnt), '1, 1'b0, 1'b0); gen_cnt++;
      drain();
      cfg_en = 0;
      model_disable();
      tick(2);
      chk("dis_locked", sts_locked, 0);
      chk("dis_tready", s_axis_tready, 0);
      cfg_en = 1;
      tick(2);
      e0: begin
         e0_e: d0 = sts_err;
      end
      send(rep(32'h55), '1, 1'b0, 1'b0);
      send(rep(32'h66), '1, 1'b0, 1'b1);
      clean_pkt(4, -1);
      drain();
      chk("reen_locked", sts_locked, 1);

      // cfg_rst mid-packet
      send(rep(gen_cnt), '1, 1'b1, 1'b0); gen_cnt++;
      send(rep(gen_cnt), '1, 1'b0, 1'b0); gen_cnt++;
      drain();
      cfg_rst = 1;
      tick(1);
      cfg_rst = 0;
      model_clear();
      check_zero("cfgrst");
      tick(2);
      send(rep(32'h77), 16'h00FF, 1'b0, 1'b0);
      send(rep(32'h78), '1, 1'b0, 1'b1);
      drain();
      chk("cfgrst_hunt_err", sts_err, 0);
      chk("cfgrst_hunt_beats", sts_beat_cnt, 2);

      // single-beat packets: SOP and EOP on the same beat, including in HUNT
      cfg_len = 1;
      for (int p = 0; p < 4; p++) clean_pkt(1, -1);
      drain();
      chk("len1_pkt", sts_pkt_cnt, 4);
      chk("len1_err", sts_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
